// File: rtl/rot_pkg.sv
// Shared types and constants for the rotation finder and its rotate-right unit.
// Optional build macro used by rotation_finder: ROT_FINDER_PARALLEL_EN.
package rot_pkg;

  // Data width and rotation-amount width of the companion barrel rotator
  localparam int ROT_W  = 8;
  localparam int ROT_AW = 3;

  // Number of distinct candidate rotations searched
  localparam int ROT_N  = 1 << ROT_AW;

  // Direction encoding shared with the rotator's lr input
  localparam logic ROT_RIGHT = 1'b1;
  localparam logic ROT_LEFT  = 1'b0;

  // Search controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } rf_state_t;

  // Recovered rotation in the rotator's own terms
  typedef struct packed {
    logic              lr;
    logic [ROT_AW-1:0] amt;
  } rf_result_t;

  // Map a matching right-rotation candidate onto the shortest equivalent
  // rotation: up to half a turn stays a right rotation, beyond that it is
  // cheaper to express as a left rotation by the complementary amount.
  function automatic rf_result_t encode_candidate(input logic [ROT_AW-1:0] c);
    rf_result_t r;
    if (c <= 3'd4) begin
      r.lr  = ROT_RIGHT;
      r.amt = c;
    end else begin
      r.lr  = ROT_LEFT;
      r.amt = 3'd0 - c;
    end
    return r;
  endfunction

endpackage

// File: rtl/rotr_unit.sv
// Combinational rotate-right of a ROT_W-bit word by a ROT_AW-bit amount.
module rotr_unit
  import rot_pkg::*;
(
  input  logic [ROT_W-1:0]  data,
  input  logic [ROT_AW-1:0] amt,
  output logic [ROT_W-1:0]  result
);

  // Explicit per-amount wiring keeps every output bit a plain mux of inputs
  always_comb begin
    result = data;
    case (amt)
      3'd0: result = data;
      3'd1: result = {data[0],   data[7:1]};
      3'd2: result = {data[1:0], data[7:2]};
      3'd3: result = {data[2:0], data[7:3]};
      3'd4: result = {data[3:0], data[7:4]};
      3'd5: result = {data[4:0], data[7:5]};
      3'd6: result = {data[5:0], data[7:6]};
      3'd7: result = {data[6:0], data[7]};
    endcase
  end

endmodule

// File: rtl/rotation_finder.sv
// Recovers the rotation amount/direction relating an original byte to a rotated
// byte, using a start/done handshake.
// Build option: define ROT_FINDER_PARALLEL_EN to evaluate all eight candidates
// in a single SEARCH cycle; otherwise one candidate is tried per clock.
module rotation_finder
  import rot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROT_W-1:0]  orig,
  input  logic [ROT_W-1:0]  rotated,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ROT_AW-1:0] amt,
  output logic              lr
);

  rf_state_t         state, state_next;
  logic [ROT_W-1:0]  orig_q, rotated_q;
  logic              hit;
  logic [ROT_AW-1:0] hit_c;
  logic              last;
  rf_result_t        enc;

  wire accept = (state == IDLE) && start;

`ifdef ROT_FINDER_PARALLEL_EN
  logic [ROT_W-1:0] cand [ROT_N];
  logic [ROT_N-1:0] match;

  for (genvar k = 0; k < ROT_N; k++) begin : g_cand
    rotr_unit u_rotr (
      .data   (orig_q),
      .amt    (ROT_AW'(k)),
      .result (cand[k])
    );
    assign match[k] = (cand[k] == rotated_q);
  end

  // Lowest matching candidate wins so periodic patterns report the minimum shift
  always_comb begin
    hit   = |match;
    hit_c = '0;
    for (int k = ROT_N - 1; k >= 0; k--) begin
      if (match[k]) hit_c = ROT_AW'(k);
    end
  end

  assign last = 1'b1;
`else
  logic [ROT_AW-1:0] c;
  logic [ROT_W-1:0]  cand;

  rotr_unit u_rotr (
    .data   (orig_q),
    .amt    (c),
    .result (cand)
  );

  assign hit   = (cand == rotated_q);
  assign hit_c = c;
  assign last  = (c == 3'(ROT_N - 1));

  // Candidate counter: restarts on an accepted start, advances on each miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
    end else if (accept) begin
      c <= '0;
    end else if ((state == SEARCH) && !hit && !last) begin
      c <= c + 3'd1;
    end
  end
`endif

  assign enc = encode_candidate(hit_c);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a search ends on the first hit or after the last candidate
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEARCH;
      SEARCH:  if (hit || last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture: later input changes cannot disturb a running search
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig_q    <= '0;
      rotated_q <= '0;
    end else if (accept) begin
      orig_q    <= orig;
      rotated_q <= rotated;
    end
  end

  // Result registers: updated only when a search concludes, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found <= 1'b0;
      amt   <= '0;
      lr    <= ROT_LEFT;
    end else if (state == SEARCH) begin
      if (hit) begin
        found <= 1'b1;
        amt   <= enc.amt;
        lr    <= enc.lr;
      end else if (last) begin
        found <= 1'b0;
        amt   <= '0;
        lr    <= ROT_LEFT;
      end
    end
  end

  assign busy = (state == SEARCH);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rotation_finder.sv
// Scoreboard bench for rotation_finder: the driver queues expected results,
// a monitor checks them whenever done is presented.
module tb_rotation_finder;
  import rot_pkg::*;

  typedef struct {
    string      name;
    logic       found;
    logic [2:0] amt;
    logic       lr;
    int         done_cycle;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] orig;
  logic [7:0] rotated;
  logic       busy;
  logic       done;
  logic       found;
  logic [2:0] amt;
  logic       lr;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cycle = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic held_found = 1'b0;
  logic [2:0] held_amt = 3'd0;
  logic held_lr = 1'b0;
  logic prev_done = 1'b0;

  rotation_finder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .orig    (orig),
    .rotated (rotated),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .amt     (amt),
    .lr      (lr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input int actual, input int required);
    n_checks++;
    if (actual == required) n_pass++;
    else $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
  endtask

  function automatic int latency(input int c);
`ifdef ROT_FINDER_PARALLEL_EN
    return 1;
`else
    return c + 1;
`endif
  endfunction

  // Issue one start pulse and queue its expected result; returns just after E0
  task automatic apply_stimulus(input string name, input logic [7:0] o, input logic [7:0] r,
                                input logic f, input logic [2:0] a, input logic d, input int c);
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    orig    = o;
    rotated = r;
    e.name  = name;
    e.found = f;
    e.amt   = a;
    e.lr    = d;
    e.done_cycle = cycle + 1 + latency(c);
    exp_q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    orig    = ~o;
    rotated = r ^ 8'h3C;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check_output({name, "_timeout"}, n, 0);
    @(negedge clk);
  endtask

  // Monitor: compare results on done, enforce single-cycle done and stable outputs while busy
  always @(negedge clk) begin
    if (!rst_n) begin
      held_found = 1'b0;
      held_amt   = 3'd0;
      held_lr    = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_done) check_output("done_single_cycle", int'(done), 0);
      if (done) begin
        check_output("busy_low_at_done", int'(busy), 0);
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", int'(done), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_output({mon_e.name, "_found"}, int'(found), int'(mon_e.found));
          check_output({mon_e.name, "_amt"}, int'(amt), int'(mon_e.amt));
          check_output({mon_e.name, "_lr"}, int'(lr), int'(mon_e.lr));
          check_output({mon_e.name, "_done_cycle"}, cycle, mon_e.done_cycle);
          held_found = mon_e.found;
          held_amt   = mon_e.amt;
          held_lr    = mon_e.lr;
        end
      end else if (busy) begin
        check_output("stable_while_busy", int'({found, amt, lr}), int'({held_found, held_amt, held_lr}));
      end
      prev_done = done;
    end
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    orig    = 8'h00;
    rotated = 8'h00;
    repeat (2) @(negedge clk);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_found", int'(found), 0);
    check_output("reset_amt", int'(amt), 0);
    check_output("reset_lr", int'(lr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors: name, orig, rotated, found, amt, lr, matching candidate
    apply_stimulus("r1_b4_5a", 8'hB4, 8'h5A, 1'b1, 3'd1, 1'b1, 1); wait_idle("r1_b4_5a");
    apply_stimulus("l2_b4_d2", 8'hB4, 8'hD2, 1'b1, 3'd2, 1'b0, 6); wait_idle("l2_b4_d2");
    apply_stimulus("r4_b4_4b", 8'hB4, 8'h4B, 1'b1, 3'd4, 1'b1, 4); wait_idle("r4_b4_4b");
    apply_stimulus("r0_ff_ff", 8'hFF, 8'hFF, 1'b1, 3'd0, 1'b1, 0); wait_idle("r0_ff_ff");
    apply_stimulus("none_b5",  8'hB4, 8'hB5, 1'b0, 3'd0, 1'b0, 7); wait_idle("none_b5");
    apply_stimulus("l3_03_18", 8'h03, 8'h18, 1'b1, 3'd3, 1'b0, 5); wait_idle("l3_03_18");
    apply_stimulus("l1_03_06", 8'h03, 8'h06, 1'b1, 3'd1, 1'b0, 7); wait_idle("l1_03_06");
    apply_stimulus("r1_55_aa", 8'h55, 8'hAA, 1'b1, 3'd1, 1'b1, 1); wait_idle("r1_55_aa");

    // A second start during the search must be ignored
    apply_stimulus("repulse", 8'hB4, 8'hD2, 1'b1, 3'd2, 1'b0, 6);
    @(negedge clk);
    start   = 1'b1;
    orig    = 8'hFF;
    rotated = 8'hFF;
    @(negedge clk);
    start   = 1'b0;
    wait_idle("repulse");

    // Reset in the middle of a search: immediate clear, no done pulse
    apply_stimulus("rst_mid", 8'hB4, 8'hD2, 1'b1, 3'd2, 1'b0, 6);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("midrst_busy", int'(busy), 0);
    check_output("midrst_done", int'(done), 0);
    check_output("midrst_found", int'(found), 0);
    check_output("midrst_amt", int'(amt), 0);
    check_output("midrst_lr", int'(lr), 0);
    if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus("after_rst", 8'hB4, 8'h5A, 1'b1, 3'd1, 1'b1, 1); wait_idle("after_rst");

    repeat (4) @(negedge clk);
    check_output("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rotation_finder.md
# rotation_finder

Sequential inverse of the team's 8-bit left/right barrel rotator: given an original byte and a rotated byte, finds the rotation amount and direction that map one to the other. It takes a start/done handshake and searches one candidate rotation per clock. It sits beside the rotator in checking and self-test paths, where it recovers `amt`/`lr` from observed data.

## Interface
Parameters: none. Width is fixed at 8 bits; amount is 3 bits.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a search. Sampled only in IDLE.
- `orig` input 8: unrotated byte. Captured on the accepted `start` edge.
- `rotated` input 8: rotated byte. Captured on the accepted `start` edge.
- `busy` output 1: high while a search is in progress.
- `done` output 1: one-cycle pulse when the result is valid.
- `found` output 1: a matching rotation exists.
- `amt` output 3: recovered rotation amount, 0..4.
- `lr` output 1: recovered direction. 1 = rotate right, 0 = rotate left. Same encoding as the rotator.

## Operation
- FSM states: IDLE, SEARCH, DONE.
- IDLE → SEARCH on `start`=1.
  - Capture `orig` and `rotated`; candidate counter `c` is set to 0.
- SEARCH, each cycle:
  - Compare rotate-right(orig_q, c) against rotated_q.
  - On a match: go to DONE. Register `found`=1.
    - If c≤4: `lr`=1, `amt`=c.
    - If c≥5: `lr`=0, `amt`=8−c.
  - On a miss with c=7: go to DONE. Register `found`=0, `amt`=0, `lr`=0.
  - Otherwise: c ← c+1 (3-bit counter, never wraps inside a search).
- DONE → IDLE unconditionally after one cycle.
  - `done`=1 only in DONE.
- The lowest matching c wins. Periodic patterns (0x00, 0xFF, 0x55, …) therefore report the minimum right-rotation.
- `start` is ignored while `busy`=1 or in DONE. No queuing.
- `found`/`amt`/`lr` hold their last result until the next search completes.
  - They do not change during SEARCH.
- Input changes after capture have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `found`=0, `amt`=0, `lr`=0. State = IDLE, c=0.
- Latency (`start` accepted at edge E0; match at candidate c):
  - `done` and results are visible after edge E(c+1).
  - `done` drops after E(c+2).
  - Worst case, no match: `done` after E8.
- `busy` rises after E0 and falls on the same edge that raises `done`.
- Back-to-back: `start` held high through DONE is accepted on the edge that returns to IDLE + 1. The minimum start-to-start spacing is c+3 cycles.
- Reset asserted mid-search:
  - Immediate return to IDLE, all outputs at reset values.
  - No `done` pulse.
  - The captured operands are discarded.

## Configuration
- `ROT_FINDER_PARALLEL_EN` defined:
  - Eight comparators evaluate all candidates in the first SEARCH cycle, with a lowest-c priority encoder.
  - `done` always appears after E1, regardless of match position.
  - Result encoding is identical.
- Not defined: serial search as above, one comparator, variable latency.
- Port list and FSM states are identical in both builds.

## Structure
- Package `rot_pkg`:
  - `ROT_W`=8 and `ROT_AW`=3.
  - State enum `rf_state_t` {IDLE, SEARCH, DONE}.
  - `lr` encoding constants `ROT_RIGHT`=1, `ROT_LEFT`=0.
- Sub-module `rotr_unit`: combinational rotate-right of `ROT_W` bits by `ROT_AW` bits.
  - Serial build: one instance.
  - Parallel build: eight instances, generated.

## Test plan
- orig=0xB4, rotated=0x5A, start pulse → after E2: `done`=1, `found`=1, `lr`=1, `amt`=1. `busy` high for exactly 2 cycles.
- orig=0xB4, rotated=0xD2 (left by 2) → c=6 → after E7: `found`=1, `lr`=0, `amt`=2.
- orig=0xB4, rotated=0x4B → after E5: `lr`=1, `amt`=4. orig=0xFF, rotated=0xFF → after E1: `amt`=0, `lr`=1.
- orig=0xB4, rotated=0xB5 → after E8: `found`=0, `amt`=0, `lr`=0, `done` a single cycle.
- `start` re-pulsed with new operands during SEARCH → ignored. The result matches the first operands. Outputs stay stable until `done`.
- `rst_n` low at E3 of the 0xD2 search → outputs 0 immediately, no `done`. A subsequent 0x5A search completes normally. With `ROT_FINDER_PARALLEL_EN`, every case above completes after E1 with the same results.
